// File: rtl/jtkicker_obj_scan_pkg.sv
// jtkicker_obj_pkg: shared states and constants for the Kicker object line scanner
package jtkicker_obj_pkg;
    typedef enum logic [2:0] {IDLE, RD_Y, CHK_Y, RD_X, ISSUE, NEXT, DONE} state_t;
    localparam logic [7:0] OBJ_H = 8'd16;
    localparam int ATTR_VF = 6;
    localparam int ATTR_HF = 5;
endpackage

// File: rtl/jtkicker_obj_scan_if.sv
// jtkicker_obj_scan_if: start/busy handshake and object fields towards the line-buffer drawer
interface jtkicker_obj_scan_if;
    logic       dr_start;
    logic       dr_busy;
    logic [8:0] dr_code;
    logic [3:0] dr_pal;
    logic [7:0] dr_xpos;
    logic [3:0] dr_row;
    logic       dr_hflip;
    logic       dr_vflip;
    modport master(output dr_start, dr_code, dr_pal, dr_xpos, dr_row, dr_hflip, dr_vflip, input dr_busy);
    modport slave(input dr_start, dr_code, dr_pal, dr_xpos, dr_row, dr_hflip, dr_vflip, output dr_busy);
endinterface

// File: rtl/jtkicker_obj_scan.sv
// jtkicker_obj_scan: per-line object RAM walker feeding the sprite drawer
// JTKICKER_OBJ_LIMIT_EN caps the objects sent per line at MAX_LINE
module jtkicker_obj_scan
    import jtkicker_obj_pkg::*;
#(
    parameter int         OBJ_NUM  = 24,
    parameter logic [9:0] OBJ_BASE = 10'h000,
    parameter int         MAX_LINE = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hinit,
    input  logic [7:0]                 vdump,
    input  logic                       flip,
    output logic [9:0]                 scan_addr,
    input  logic [7:0]                 low_q,
    input  logic [7:0]                 high_q,
    jtkicker_obj_scan_if.master        dr,
    output logic                       scan_busy
);
    localparam int NW = $clog2(OBJ_NUM);
    state_t        st, st_nx;
    logic [NW-1:0] n;
    logic [7:0]    line, code, ydiff;
    logic [3:0]    row_l;
    logic          flip_l, vis, last, send, vf, limit_hit;
    logic [7:0]    line_nx;
    assign line_nx = vdump + 8'd1;
    assign ydiff   = line - high_q;
    assign vis     = ydiff < OBJ_H;
    assign last    = n == NW'(OBJ_NUM - 1);
    assign send    = st == ISSUE && !dr.dr_busy && !hinit;
    assign vf      = low_q[ATTR_VF] ^ flip_l;
`ifdef JTKICKER_OBJ_LIMIT_EN
    localparam int CW = $clog2(MAX_LINE + 1);
    logic [CW-1:0] cnt;
    assign limit_hit = cnt == CW'(MAX_LINE);
    always_ff @(posedge clk)
        cnt <= rst || hinit ? '0 : cnt + CW'(send);
`else
    assign limit_hit = 1'b0;
`endif
    always_ff @(posedge clk)
        st <= rst ? IDLE : st_nx;
    // a line pulse in any state restarts the walk, so it overrides every transition
    always_comb begin
        st_nx = IDLE;
        if (hinit) st_nx = RD_Y;
        else case (st)
            RD_Y:    st_nx = CHK_Y;
            CHK_Y:   st_nx = limit_hit ? DONE : vis ? RD_X : NEXT;
            RD_X:    st_nx = ISSUE;
            ISSUE:   st_nx = dr.dr_busy ? ISSUE : NEXT;
            NEXT:    st_nx = last ? DONE : RD_Y;
            default: st_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_addr   <= OBJ_BASE;
            n           <= '0;
            line        <= '0;
            flip_l      <= 1'b0;
            code        <= '0;
            row_l       <= '0;
            scan_busy   <= 1'b0;
            dr.dr_start <= 1'b0;
            dr.dr_code  <= '0;
            dr.dr_pal   <= '0;
            dr.dr_xpos  <= '0;
            dr.dr_row   <= '0;
            dr.dr_hflip <= 1'b0;
            dr.dr_vflip <= 1'b0;
        end else begin
            dr.dr_start <= send;
            scan_busy   <= hinit || (scan_busy && st != DONE);
            if (hinit) begin
                line      <= flip ? ~line_nx : line_nx;
                flip_l    <= flip;
                n         <= '0;
                scan_addr <= OBJ_BASE;
            end else begin
                if (st == CHK_Y && vis && !limit_hit) begin
                    code      <= low_q;
                    row_l     <= ydiff[3:0];
                    scan_addr <= scan_addr + 10'd1;
                end
                if (st == ISSUE) begin
                    dr.dr_code  <= {low_q[7], code};
                    dr.dr_pal   <= low_q[3:0];
                    dr.dr_xpos  <= flip_l ? 8'd240 - high_q : high_q;
                    dr.dr_row   <= row_l ^ {4{vf}};
                    dr.dr_hflip <= low_q[ATTR_HF] ^ flip_l;
                    dr.dr_vflip <= vf;
                end
                if (st == NEXT && !last) begin
                    n         <= n + NW'(1);
                    scan_addr <= OBJ_BASE + 10'({n + NW'(1), 1'b0});
                end
            end
        end
    end
endmodule
